// File: rtl/counter_compare.sv
// Compare/PWM stage behind the prescaled counter: per-channel compare registers,
// match flags (W1C) with interrupt, registered PWM levels, iomem-style register bus.

module counter_compare_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             cnt_tick,
    input  logic [CNT_W-1:0] cnt_value,
    input  logic [3:0]       cmp_we,
    input  logic [CNT_W-1:0] wdata,
    input  logic             clr,
    output logic [CNT_W-1:0] cmp,
    output logic             flag,
    output logic             pwm
);
    // compare and PWM both see the pre-write CMP value in a write cycle
    logic hit;
    assign hit = cnt_tick && en && (cnt_value == cmp);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp  <= '0;
            flag <= 1'b0;
            pwm  <= 1'b0;
        end else begin
            for (int b = 0; b < CNT_W; b++)
                if (cmp_we[b/8]) cmp[b] <= wdata[b];
            flag <= hit | (flag & ~clr);
            pwm  <= en && (cnt_value < cmp);
        end
    end
endmodule

module counter_compare #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [3:0]       reg_we,
    input  logic [3:0]       reg_re,
    input  logic [3:0]       reg_addr,
    input  logic [31:0]      reg_di,
    output logic [31:0]      reg_do,
    output logic             ready,
    input  logic [CNT_W-1:0] cnt_value,
    input  logic             cnt_tick,
    output logic [NUM_CH-1:0] pwm_out,
    output logic             irq
);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t                        state, state_nxt;
    logic                          do_wr, do_rd;
    logic                          wr_req, rd_req;
    logic                          en;
    logic [NUM_CH-1:0]             ie;
    logic [NUM_CH-1:0]             flag;
    logic [NUM_CH-1:0]             clr;
    logic [NUM_CH-1:0][CNT_W-1:0]  cmp;
    logic [31:0]                   rdata;

    assign wr_req = |reg_we;
    assign rd_req = |reg_re;

    always_comb begin
        state_nxt = state;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    do_wr     = 1'b1;
                    state_nxt = ACK;
                end else if (rd_req) begin
                    do_rd     = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = HOLD;
            HOLD:    if (!wr_req && !rd_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (reg_addr)
            4'd0: begin
                rdata[0]          = en;
                rdata[8 +: NUM_CH] = ie;
            end
            4'd1:    rdata[NUM_CH-1:0] = flag;
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    if (reg_addr == 4'(ch + 2)) rdata[CNT_W-1:0] = cmp[ch];
            end
        endcase
    end

    assign clr = (do_wr && reg_addr == 4'd1 && reg_we[0]) ? reg_di[NUM_CH-1:0] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            ready  <= 1'b0;
            reg_do <= '0;
            en     <= 1'b0;
            ie     <= '0;
            irq    <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == ACK);
            if (do_rd)
                reg_do <= rdata;
            else if (state == HOLD && state_nxt == IDLE)
                reg_do <= '0;
            if (do_wr && reg_addr == 4'd0) begin
                if (reg_we[0]) en <= reg_di[0];
                if (reg_we[1]) ie <= reg_di[8 +: NUM_CH];
            end
            irq <= |(flag & ie);
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [3:0] cmp_we;
        assign cmp_we = (do_wr && reg_addr == 4'(ch + 2)) ? reg_we : 4'b0000;

        counter_compare_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .resetn    (resetn),
            .en        (en),
            .cnt_tick  (cnt_tick),
            .cnt_value (cnt_value),
            .cmp_we    (cmp_we),
            .wdata     (reg_di[CNT_W-1:0]),
            .clr       (clr[ch]),
            .cmp       (cmp[ch]),
            .flag      (flag[ch]),
            .pwm       (pwm_out[ch])
        );
    end
endmodule
